// File: rtl/ascon_pkg.sv
// Shared Ascon constants, lane/state types and the AD-absorb FSM encoding.
// Used by the round function and by the absorption controller.
package ascon_pkg;
  localparam int LANE_W   = 64;
  localparam int RATE_W   = 128;
  localparam int ROUNDS_B = 8;

  localparam logic [63:0] AEAD128_IV = 64'h0000_1000_808c_0001;
  localparam logic [63:0] DSEP_MASK  = 64'h8000_0000_0000_0000;

  // Index 0 is the first constant of p12; p8 uses indices 4..11.
  localparam logic [11:0][7:0] RC_TABLE = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
    8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
  };

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    lane_t x0;
    lane_t x1;
    lane_t x2;
    lane_t x3;
    lane_t x4;
  } state_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PERM = 3'd2,
    ST_PAD  = 3'd3,
    ST_SEP  = 3'd4,
    ST_DONE = 3'd5
  } absorb_state_e;

  function automatic lane_t ror64(input lane_t v, input int unsigned n);
    return (v >> n) | (v << (LANE_W - n));
  endfunction
endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear layer.
// Shared by every permutation stage of the core.
module ascon_round import ascon_pkg::*; (
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  input  logic [7:0]  rc_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);
  lane_t a0, a1, a2, a3, a4;
  lane_t b0, b1, b2, b3, b4;
  lane_t s0, s1, s2, s3, s4;

  always_comb begin
    // Round constant folds into the S-box input XOR layer on x2.
    a0 = x0_i ^ x4_i;
    a1 = x1_i;
    a2 = x2_i ^ {56'h0, rc_i} ^ x1_i;
    a3 = x3_i;
    a4 = x4_i ^ x3_i;

    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);

    s0 = b0 ^ b4;
    s1 = b1 ^ b0;
    s2 = ~b2;
    s3 = b3 ^ b2;
    s4 = b4;
  end

  assign x0_o = s0 ^ ror64(s0, 19) ^ ror64(s0, 28);
  assign x1_o = s1 ^ ror64(s1, 61) ^ ror64(s1, 39);
  assign x2_o = s2 ^ ror64(s2, 1)  ^ ror64(s2, 6);
  assign x3_o = s3 ^ ror64(s3, 10) ^ ror64(s3, 17);
  assign x4_o = s4 ^ ror64(s4, 7)  ^ ror64(s4, 41);
endmodule

// File: rtl/ascon_ad_absorb.sv
// Ascon-AEAD128 associated-data absorption: pads and XORs 128-bit AD blocks into the
// rate, runs p8 one round per cycle, applies domain separation, then pulses done.
module ascon_ad_absorb import ascon_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  x0_i,
  input  logic [63:0]  x1_i,
  input  logic [63:0]  x2_i,
  input  logic [63:0]  x3_i,
  input  logic [63:0]  x4_i,
  input  logic         ad_empty,
  input  logic         ad_valid,
  output logic         ad_ready,
  input  logic [127:0] ad_data,
  input  logic [4:0]   ad_bytes,
  input  logic         ad_last,
  output logic         busy,
  output logic         done,
  output logic [63:0]  x0_o,
  output logic [63:0]  x1_o,
  output logic [63:0]  x2_o,
  output logic [63:0]  x3_o,
  output logic [63:0]  x4_o
);
  localparam int               CNT_W    = $clog2(ROUNDS_B);
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS_B - 1);
  localparam logic [3:0]       RC_BASE  = 4'(12 - ROUNDS_B);

  absorb_state_e     state_q, state_d;
  state_t            x_q, x_d, rnd_out;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              padp_q, padp_d;
  logic [4:0]        n_eff;
  logic              pad_short;
  logic [RATE_W-1:0] blk;
  logic [7:0]        rc;

  assign rc = RC_TABLE[RC_BASE + 4'(cnt_q)];

  ascon_round u_round (
    .x0_i (x_q.x0),
    .x1_i (x_q.x1),
    .x2_i (x_q.x2),
    .x3_i (x_q.x3),
    .x4_i (x_q.x4),
    .rc_i (rc),
    .x0_o (rnd_out.x0),
    .x1_o (rnd_out.x1),
    .x2_o (rnd_out.x2),
    .x3_o (rnd_out.x3),
    .x4_o (rnd_out.x4)
  );

  // A byte count of 0 (illegal) or above 16 behaves as a full block.
  always_comb begin
    n_eff     = (ad_bytes == 5'd0 || ad_bytes > 5'd16) ? 5'd16 : ad_bytes;
    pad_short = ad_last && (n_eff < 5'd16);
    blk       = ad_data;
    for (int i = 0; i < 16; i++) begin
      if (pad_short && (5'(i) >= n_eff)) begin
        blk[8*i +: 8] = (5'(i) == n_eff) ? 8'h01 : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ad_empty ? ST_SEP : ST_WAIT;
      ST_WAIT: if (ad_valid) state_d = ST_PERM;
      ST_PERM: begin
        if (cnt_q == LAST_RND) begin
          if (!last_q)     state_d = ST_WAIT;
          else if (padp_q) state_d = ST_PAD;
          else             state_d = ST_SEP;
        end
      end
      ST_PAD:  state_d = ST_PERM;
      ST_SEP:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ad_ready = (state_q == ST_WAIT);
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
  end

  always_comb begin
    x_d    = x_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    padp_d = padp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d    = '{x0: x0_i, x1: x1_i, x2: x2_i, x3: x3_i, x4: x4_i};
          cnt_d  = '0;
          last_d = 1'b0;
          padp_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (ad_valid) begin
          x_d.x0 = x_q.x0 ^ blk[63:0];
          x_d.x1 = x_q.x1 ^ blk[127:64];
          cnt_d  = '0;
          last_d = ad_last;
          padp_d = ad_last && (n_eff == 5'd16);
        end
      end
      ST_PERM: begin
        x_d   = rnd_out;
        cnt_d = cnt_q + 1'b1;
      end
      // A full final block still needs the lone 0x01 padding block.
      ST_PAD: begin
        x_d.x0 = x_q.x0 ^ 64'h1;
        cnt_d  = '0;
        padp_d = 1'b0;
      end
      ST_SEP:  x_d.x4 = x_q.x4 ^ DSEP_MASK;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      padp_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      padp_q <= padp_d;
    end
  end

  assign x0_o = x_q.x0;
  assign x1_o = x_q.x1;
  assign x2_o = x_q.x2;
  assign x3_o = x_q.x3;
  assign x4_o = x_q.x4;

  a_last_bytes_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_WAIT && ad_valid && ad_last) |-> (ad_bytes != 5'd0));
endmodule

// File: tb/tb_ascon_ad_absorb.sv
// Scoreboard bench for ascon_ad_absorb: stimulus pushes expected final state and done
// cycle, a monitor pops and compares on every done pulse.
module tb_ascon_ad_absorb;
  typedef logic [63:0] lane_t;
  typedef struct packed {
    lane_t x0, x1, x2, x3, x4;
    int unsigned at;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  x0_i = '0, x1_i = '0, x2_i = '0, x3_i = '0, x4_i = '0;
  logic         ad_empty = 1'b0;
  logic         ad_valid = 1'b0;
  logic         ad_ready;
  logic [127:0] ad_data = '0;
  logic [4:0]   ad_bytes = '0;
  logic         ad_last = 1'b0;
  logic         busy, done;
  logic [63:0]  x0_o, x1_o, x2_o, x3_o, x4_o;

  ascon_ad_absorb dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
    .ad_empty(ad_empty), .ad_valid(ad_valid), .ad_ready(ad_ready),
    .ad_data(ad_data), .ad_bytes(ad_bytes), .ad_last(ad_last),
    .busy(busy), .done(done),
    .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  bit ready_seen = 1'b0;
  string cur_name = "reset";
  exp_t sb_q [$];

  logic [4:0]   sbox_t [32];
  logic [7:0]   rc_t [8];
  lane_t        m [5];
  lane_t        tv_x [5];
  logic [127:0] tv_dat [4];
  int           tv_n [4];
  int           tv_stall [4];

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic lane_t rotr(input lane_t v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Reference round built from the 5-bit S-box table, one bit column at a time.
  task automatic model_round(input int r);
    lane_t s [5];
    logic [4:0] col, o;
    m[2] = m[2] ^ {56'h0, rc_t[r]};
    for (int b = 0; b < 64; b++) begin
      col = {m[0][b], m[1][b], m[2][b], m[3][b], m[4][b]};
      o = sbox_t[col];
      for (int k = 0; k < 5; k++) s[k][b] = o[4-k];
    end
    m[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
    m[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
    m[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
    m[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
    m[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
  endtask

  task automatic model_p8();
    for (int r = 0; r < 8; r++) model_round(r);
  endtask

  task automatic model_absorb(input logic [127:0] d, input int n, input bit last);
    logic [7:0] by [16];
    for (int i = 0; i < 16; i++) by[i] = d[8*i +: 8];
    if (last && n < 16) begin
      for (int i = n; i < 16; i++) by[i] = 8'h00;
      by[n] = 8'h01;
    end
    for (int i = 0; i < 8; i++) begin
      m[0][8*i +: 8] = m[0][8*i +: 8] ^ by[i];
      m[1][8*i +: 8] = m[1][8*i +: 8] ^ by[8+i];
    end
    model_p8();
    if (last && n == 16) begin
      m[0][7:0] = m[0][7:0] ^ 8'h01;
      model_p8();
    end
  endtask

  always @(posedge clk) if (rst_n && ad_valid && ad_ready) hs_cnt++;
  always @(negedge clk) if (ad_ready) ready_seen = 1'b1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk64({cur_name, "_unexpected_done"}, 64'(done), 64'h0);
      end else begin
        e = sb_q.pop_front();
        chk64({cur_name, "_x0"}, x0_o, e.x0);
        chk64({cur_name, "_x1"}, x1_o, e.x1);
        chk64({cur_name, "_x2"}, x2_o, e.x2);
        chk64({cur_name, "_x3"}, x3_o, e.x3);
        chk64({cur_name, "_x4"}, x4_o, e.x4);
        chk64({cur_name, "_done_edge"}, 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic run_test(input string nm, input bit empty, input int nb, input bit disturb);
    int unsigned s;
    int blocks, stall, hs0, k;
    exp_t e;
    cur_name = nm;
    for (int i = 0; i < 5; i++) m[i] = tv_x[i];
    blocks = 0;
    stall  = 0;
    if (!empty) begin
      for (int b = 0; b < nb; b++) begin
        model_absorb(tv_dat[b], tv_n[b], b == nb - 1);
        blocks += (b == nb - 1 && tv_n[b] == 16) ? 2 : 1;
        stall  += tv_stall[b];
      end
    end
    m[4] = m[4] ^ 64'h8000_0000_0000_0000;

    @(negedge clk);
    x0_i = tv_x[0]; x1_i = tv_x[1]; x2_i = tv_x[2]; x3_i = tv_x[3]; x4_i = tv_x[4];
    ad_empty = empty;
    start = 1'b1;
    s = cyc + 1;
    e = '{x0: m[0], x1: m[1], x2: m[2], x3: m[3], x4: m[4],
          at: s + 1 + 9 * blocks + stall};
    sb_q.push_back(e);
    hs0 = hs_cnt;
    ready_seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    x0_i = '1; x1_i = '1; x2_i = '1; x3_i = '1; x4_i = '1;
    chk64({nm, "_busy_after_start"}, 64'(busy), 64'h1);

    if (!empty) begin
      for (int b = 0; b < nb; b++) begin
        if (tv_stall[b] > 0) begin
          ad_valid = 1'b0;
          k = 0;
          while (!ad_ready && k < 100) begin @(negedge clk); k++; end
          repeat (tv_stall[b]) @(negedge clk);
        end
        ad_valid = 1'b1;
        ad_data  = tv_dat[b];
        ad_bytes = 5'(tv_n[b]);
        ad_last  = (b == nb - 1);
        k = 0;
        while (!ad_ready && k < 100) begin @(negedge clk); k++; end
        chk64({nm, "_ready_reached"}, 64'(ad_ready), 64'h1);
        @(negedge clk);
        ad_valid = 1'b0;
      end
      if (disturb) begin
        ad_valid = 1'b1;
        ad_data  = '1;
        ad_bytes = 5'd3;
        ad_last  = 1'b0;
        @(negedge clk);
        ad_empty = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    k = 0;
    while (sb_q.size() != 0 && k < 400) begin @(negedge clk); k++; end
    chk64({nm, "_drained"}, 64'(sb_q.size()), 64'h0);
    sb_q.delete();
    ad_valid = 1'b0;
    @(negedge clk);
    chk64({nm, "_busy_idle"}, 64'(busy), 64'h0);
    chk64({nm, "_done_single"}, 64'(done), 64'h0);
    chk64({nm, "_hold_x0"}, x0_o, m[0]);
    chk64({nm, "_hold_x4"}, x4_o, m[4]);
    chk64({nm, "_handshakes"}, 64'(hs_cnt - hs0), empty ? 64'h0 : 64'(nb));
    if (empty) chk64({nm, "_no_ready"}, 64'(ready_seen), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    sbox_t = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
               5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
               5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
               5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    rc_t = '{8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    tv_stall = '{0, 0, 0, 0};

    repeat (2) @(negedge clk);
    chk64("reset_x0", x0_o, 64'h0);
    chk64("reset_x4", x4_o, 64'h0);
    chk64("reset_busy", 64'(busy), 64'h0);
    chk64("reset_done", 64'(done), 64'h0);
    chk64("reset_ready", 64'(ad_ready), 64'h0);
    rst_n = 1'b1;

    tv_x = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    run_test("empty_zero", 1'b1, 0, 1'b0);
    chk64("empty_zero_x4_const", x4_o, 64'h8000_0000_0000_0000);
    chk64("empty_zero_x0_const", x0_o, 64'h0);

    tv_x = '{64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
             64'h8796a5b4c3d2e1f0, 64'h1122334455667788};
    tv_dat[0] = 128'h0000_0000_0000_0000_0000_0005_0403_0201;
    tv_n[0] = 5;
    run_test("partial5", 1'b0, 1, 1'b0);

    tv_x = '{64'hdeadbeefcafef00d, 64'h0, 64'h5555aaaa5555aaaa, 64'h1, 64'h8000000000000001};
    tv_dat[0] = 128'h00112233445566778899aabbccddeeff;
    tv_n[0] = 16;
    run_test("full16", 1'b0, 1, 1'b0);

    tv_x = '{64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
             64'h8796a5b4c3d2e1f0, 64'h1122334455667788};
    tv_dat[0] = 128'hdeadbeef_01234567_89abcdef_feedface;
    tv_dat[1] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    tv_dat[2] = 128'hffeeddcc_bbaa9988_77665544_33221100;
    tv_n = '{16, 16, 7, 0};
    tv_stall = '{0, 4, 0, 0};
    run_test("three_blk_stall", 1'b0, 3, 1'b0);
    tv_stall = '{0, 0, 0, 0};

    tv_dat[0] = 128'h0000_0000_0000_0000_0000_0005_0403_0201;
    tv_n[0] = 5;
    run_test("partial5_disturbed", 1'b0, 1, 1'b1);

    // Abort during round 4 of the first permutation.
    cur_name = "reset_abort";
    @(negedge clk);
    x0_i = tv_x[0]; x1_i = tv_x[1]; x2_i = tv_x[2]; x3_i = tv_x[3]; x4_i = tv_x[4];
    ad_empty = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ad_valid = 1'b1; ad_data = tv_dat[0]; ad_bytes = 5'd5; ad_last = 1'b1;
    @(negedge clk);
    ad_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk64("abort_x0", x0_o, 64'h0);
    chk64("abort_x1", x1_o, 64'h0);
    chk64("abort_x4", x4_o, 64'h0);
    chk64("abort_busy", 64'(busy), 64'h0);
    chk64("abort_done", 64'(done), 64'h0);
    chk64("abort_ready", 64'(ad_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_test("post_reset_empty", 1'b1, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
